// File: rtl/dcache_refill_ctrl.sv
// Data-cache line refill: collects eight memory beats, then writes them into one way of the data array.
// Latency: array write happens the cycle after the eighth beat; request-to-write is at least 9 cycles.
// Backpressure: one request per IDLE visit; beats only consumed in COLLECT; a malformed line is dropped with refill_err.
module dcache_refill_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             refill_req_valid,
    output logic                             refill_req_ready,
    input  logic [ADDR_WIDTH-1:0]            refill_req_index,
    input  logic                             refill_req_way,
    input  logic                             mem_beat_valid,
    output logic                             mem_beat_ready,
    input  logic [DATA_WIDTH-1:0]            mem_beat_data,
    input  logic                             mem_beat_last,
    output logic [7:0]                       we_way0,
    output logic [7:0]                       ce_way0,
    output logic [7:0]                       we_way1,
    output logic [7:0]                       ce_way1,
    output logic [ADDR_WIDTH-1:0]            writewayaddr_way0,
    output logic [ADDR_WIDTH-1:0]            writewayaddr_way1,
    output logic [7:0][DATA_WIDTH-1:0]       din_way0,
    output logic [7:0][DATA_WIDTH-1:0]       din_way1,
    output logic [7:0][DATA_WIDTH-1:0]       wmask_way0,
    output logic [7:0][DATA_WIDTH-1:0]       wmask_way1,
    output logic                             busy,
    output logic                             refill_done,
    output logic                             refill_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]       idx_q, idx_d;
    logic                        way_q, way_d;
    logic                        err_q, err_d;
    logic [7:0][DATA_WIDTH-1:0]  buf_q;
    logic                        beat_acc;
    logic                        wr_now;

    // A beat is consumed only while collecting; reset blocks consumption in its own cycle.
    assign beat_acc = (state_q == COLLECT) && mem_beat_valid && !reset;

    // State register and latched request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            way_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            err_q   <= err_d;
        end
    end

    // Line buffer: beat k lands in slot k; stalls leave it untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q <= '0;
        end else if (beat_acc) begin
            buf_q[cnt_q] <= mem_beat_data;
        end
    end

    // Next-state logic: accept request, count beats, detect malformed lines.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        way_d   = way_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (refill_req_valid) begin
                    idx_d   = refill_req_index;
                    way_d   = refill_req_way;
                    cnt_d   = 3'd0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (mem_beat_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    if ((cnt_q == 3'd7) && mem_beat_last) begin
                        state_d = WRITE;
                    end else if ((cnt_q == 3'd7) || mem_beat_last) begin
                        // Short or overlong line: drop it and flag the error next cycle.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; reset suppresses every strobe in the cycle it is asserted.
    always_comb begin
        wr_now            = (state_q == WRITE) && !reset;
        refill_req_ready  = (state_q == IDLE) && !reset;
        mem_beat_ready    = (state_q == COLLECT) && !reset;
        busy              = (state_q != IDLE) && !reset;
        refill_done       = wr_now;
        refill_err        = err_q && !reset;
        we_way0           = (wr_now && !way_q) ? 8'hFF : 8'h00;
        ce_way0           = (wr_now && !way_q) ? 8'hFF : 8'h00;
        we_way1           = (wr_now &&  way_q) ? 8'hFF : 8'h00;
        ce_way1           = (wr_now &&  way_q) ? 8'hFF : 8'h00;
        writewayaddr_way0 = wr_now ? idx_q : '0;
        writewayaddr_way1 = wr_now ? idx_q : '0;
        din_way0          = buf_q;
        din_way1          = buf_q;
        wmask_way0        = wr_now ? '1 : '0;
        wmask_way1        = wr_now ? '1 : '0;
    end

endmodule

// File: doc/dcache_refill_ctrl.md
DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one bank word and one memory beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, set-index width driven to the data array.
REQ-003 SHALL use one clock with synchronous, active-high reset: port clock (input, 1, rising-edge clock); port reset (input, 1, synchronous active-high reset).
REQ-004 SHALL have the following request ports:
- refill_req_valid  input  1: refill request present.
- refill_req_ready  output  1: request accepted this cycle.
- refill_req_index  input  ADDR_WIDTH: set index to fill.
- refill_req_way  input  1: victim way, 0 or 1.
REQ-005 SHALL have the following memory-beat ports:
- mem_beat_valid  input  1: memory beat present.
- mem_beat_ready  output  1: beat accepted this cycle.
- mem_beat_data  input  DATA_WIDTH: beat payload; beat k fills bank k.
- mem_beat_last  input  1: final beat of line.
REQ-006 SHALL have the following data-array ports:
- we_way0, ce_way0, we_way1, ce_way1  output  8: per-bank write/chip enables.
- writewayaddr_way0, writewayaddr_way1  output  ADDR_WIDTH: write index.
- din_way0, din_way1  output  8 x DATA_WIDTH: bank write data.
- wmask_way0, wmask_way1  output  8 x DATA_WIDTH: bank write masks.
REQ-007 SHALL have the following status ports:
- busy  output  1: FSM not IDLE.
- refill_done  output  1: one-cycle pulse on line write.
- refill_err  output  1: one-cycle pulse on aborted line.

Function
REQ-008 SHALL implement FSM states IDLE, COLLECT, WRITE.
REQ-009 IDLE: refill_req_ready=1; when refill_req_valid=1, SHALL latch index and way, clear beat counter, and go to COLLECT.
REQ-010 COLLECT: mem_beat_ready=1; refill_req_ready=0; each cycle with mem_beat_valid=1 SHALL store mem_beat_data into buffer[cnt] and increment the 3-bit counter cnt.
REQ-011 When the accepted beat has cnt=7 and mem_beat_last=1, SHALL go to WRITE.
REQ-012 When the accepted beat has cnt=7 and mem_beat_last=0, or cnt<7 and mem_beat_last=1: SHALL pulse refill_err for one cycle the next cycle, perform no array write, and return to IDLE.
REQ-013 WRITE, exactly one cycle: SHALL drive we and ce = 8'hFF on the latched way only (the other way 8'h00), both writewayaddr ports = latched index, din_wayX[k] = buffer[k], all wmask words all-ones; refill_done=1; next state IDLE.
REQ-014 Outside WRITE, all we and ce SHALL be 0; din, wmask and addr values are don't-care but SHALL be deterministic (buffer contents, zeros).
REQ-015 Latency: WRITE SHALL occur the cycle after the eighth beat is accepted; minimum request-to-write time is 9 cycles.
REQ-016 mem_beat_valid in IDLE or WRITE SHALL be ignored (not consumed); refill_req_valid outside IDLE SHALL be ignored.
REQ-017 Back-to-back: a request presented in the cycle after WRITE SHALL be accepted (IDLE ready); no request is accepted during WRITE.
REQ-018 busy SHALL be 1 in COLLECT and WRITE, 0 in IDLE.
REQ-019 Beat stalls (mem_beat_valid=0) in COLLECT SHALL hold cnt and buffer unchanged, indefinitely.

Reset
REQ-020 Reset SHALL force state IDLE, cnt=0, latched index/way=0, buffer=0, refill_done=0, refill_err=0, all we/ce=0, busy=0.
REQ-021 Reset asserted during COLLECT or WRITE SHALL abandon the line: no array write occurs in the reset cycle or after.
REQ-022 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-023 Request idx=0x1A5, way=1; 8 beats 0x10..0x17 back-to-back, last on beat 8 -> one WRITE cycle: we_way1=ce_way1=8'hFF, we_way0=0, writewayaddr_way1=0x1A5, din_way1[k]=0x10+k, refill_done=1.
REQ-024 Same as REQ-023 with random valid gaps on beats (up to 5 idle cycles) -> identical write contents; WRITE one cycle after eighth beat.
REQ-025 mem_beat_last asserted on beat 5 -> refill_err pulse, no we/ce asserted, busy=0, next request accepted.
REQ-026 Reset asserted after 4 beats -> state IDLE, no write; fresh request to way 0 completes normally with correct data.
REQ-027 Request held valid through a full refill -> exactly one acceptance per IDLE visit; second refill begins the cycle after WRITE.
REQ-028 Beats presented while IDLE -> mem_beat_ready=0, beats not consumed, buffer unchanged.
